// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV64M multiply/divide unit (MUL, MULHU, DIV, DIVU, REM, REMU).
// Radix-2 shift-add multiply, restoring radix-2 divide; XLEN+3 cycles per op,
// single-cycle fast path for unsupported ops and divide-by-zero.
module muldiv_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   mcand;   // multiplicand (mul) or |divisor| (div)
  logic [2*XLEN-1:0] acc;     // product accumulator; low half starts as multiplier
  logic [XLEN:0]     rem;     // partial remainder, one guard bit
  logic [XLEN-1:0]   quo;     // dividend shifts out the top, quotient bits shift in
  logic [CNT_W-1:0]  cnt;
  logic              qneg, rneg;

  // request decode on the raw inputs (only used while IDLE)
  logic            in_sup, in_div, in_sgn, in_rem, in_div0;
  logic [XLEN-1:0] a_abs, b_abs;
  assign in_sup  = (op == 3'b000) || (op == 3'b011) || op[2];
  assign in_div  = op[2];
  assign in_sgn  = op[2] & ~op[0];
  assign in_rem  = op[2] & op[1];
  assign in_div0 = in_div && (rs2_data == '0);
  assign a_abs   = (in_sgn && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
  assign b_abs   = (in_sgn && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

  // one shift-add multiply step: conditionally add multiplicand to the high half, shift right
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] acc_n;
  assign msum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
  assign acc_n = {msum, acc[XLEN-1:1]};

  // one restoring divide step: shift in next dividend bit, subtract divisor if it fits
  logic [XLEN:0] shl, rem_n;
  logic          ge;
  assign shl   = {rem[XLEN-1:0], quo[XLEN-1]};
  assign ge    = shl >= {1'b0, mcand};
  assign rem_n = ge ? (shl - {1'b0, mcand}) : shl;

  // result select and sign fix-up; mul ops never set qneg/rneg
  logic [XLEN-1:0] raw, res;
  logic            neg;
  assign raw = op_q[2] ? (op_q[1] ? rem[XLEN-1:0] : quo)
                       : (op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]);
  assign neg = op_q[1] ? rneg : qneg;
  assign res = neg ? -raw : raw;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (!in_sup || in_div0) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(XLEN-1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // datapath: latch operands, iterate, and load the write-back registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      rd_q    <= '0;
      mcand   <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          rd_q  <= rd_in;
          cnt   <= '0;
          acc   <= {{XLEN{1'b0}}, rs2_data};
          mcand <= in_div ? b_abs : rs1_data;
          quo   <= a_abs;
          rem   <= '0;
          qneg  <= in_sgn & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
          rneg  <= in_sgn & rs1_data[XLEN-1];
          if (!in_sup) begin
            wb_rd   <= rd_in;
            wb_data <= '0;
          end else if (in_div0) begin
            wb_rd   <= rd_in;
            wb_data <= in_rem ? rs1_data : {XLEN{1'b1}};
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[2]) begin
            rem <= rem_n;
            quo <= {quo[XLEN-2:0], ge};
          end else begin
            acc <= acc_n;
          end
        end
        FIX: begin
          wb_rd   <= rd_q;
          wb_data <= res;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wb_valid = done && (wb_rd != 5'd0);

endmodule
